// File: rtl/spi_frame_master.sv
// SPI frame master: one DATA_W-bit word per valid/ready handshake, sent MSB-first as whole
// bytes inside a single ss-low window, with MISO captured into o_rx_data over the same frame.
module spi_frame_master #(
  parameter int DATA_W     = 14,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss
);

  localparam int NUM_BYTES = (DATA_W + 7) / 8;
  localparam int FRAME_W   = NUM_BYTES * 8;
  localparam int CNT_MAX   = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  HALF_LEN  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  // sclk level during the first half of every bit; the second half is its inverse.
  localparam logic PHASE_A = CPOL ^ CPHA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rx_data_d;
  logic                done_d, aborted_d;
  logic                ss_d, sclk_d, mosi_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = o_rx_data;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_valid) begin
          state_d = S_SETUP;
          tx_d    = FRAME_W'(i_data);
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        // MISO is taken on the edge that moves sclk from phase A to phase B.
        if (cnt_q == HALF_LAST) rx_d = DATA_W'({rx_q, miso});
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7 && byte_q == LAST_BYTE) begin
            state_d = S_HOLD;
          end else begin
            tx_d = tx_q << 1;
            if (bit_q == 3'd7) begin
              byte_d  = byte_q + BYTE_W'(1);
              state_d = (GAP_CYCLES == 0) ? S_SHIFT : S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HALF_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Completion in the same cycle takes priority over an abort.
    if (i_abort && state_q != S_IDLE && !done_d) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end

    ss_d   = (state_d == S_IDLE);
    sclk_d = (state_d == S_SHIFT) ? ((cnt_d < HALF_LEN) ? PHASE_A : ~PHASE_A) : CPOL;
    mosi_d = (state_d == S_IDLE) ? 1'b0 : tx_d[FRAME_W-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register updates from pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      // NOTE: the shift registers are a few flops, so they are reset with the rest of the state.
      tx_q      <= '0;
      rx_q      <= '0;
      o_rx_data <= '0;
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
      o_busy    <= 1'b0;
      o_ready   <= 1'b1;
      ss        <= 1'b1;
      sclk      <= CPOL;
      mosi      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      o_rx_data <= rx_data_d;
      o_done    <= done_d;
      o_aborted <= aborted_d;
      o_busy    <= (state_d != S_IDLE);
      o_ready   <= (state_d == S_IDLE);
      ss        <= ss_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: three parameterisations driven with directed and random frames,
// an SPI slave/monitor observing the pins, and a frame-level reference model.
module tb_spi_frame_master;

  localparam int P0_DW = 14, P0_CD = 4, P0_GAP = 2;
  localparam bit P0_CPOL = 1'b0, P0_CPHA = 1'b0;
  localparam int P1_DW = 16, P1_CD = 3, P1_GAP = 1;
  localparam bit P1_CPOL = 1'b1, P1_CPHA = 1'b1;
  localparam int P2_DW = 8, P2_CD = 1, P2_GAP = 0;
  localparam bit P2_CPOL = 1'b0, P2_CPHA = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  valid = '0;
  logic [2:0]  abort_in = '0;
  logic [31:0] data_in [3];
  wire  [2:0]  ready_w, busy_w, done_w, aborted_w, sclk_w, mosi_w, ss_w, miso_in;
  wire  [P0_DW-1:0] rx0;
  wire  [P1_DW-1:0] rx1;
  wire  [P2_DW-1:0] rx2;

  // Slave/monitor state, written only by the monitor process.
  int          edges = 0, nbits = 0, ss_low = 0, bad_mosi = 0, bad_idle = 0;
  int          done_cnt = 0, abort_cnt = 0, pidx = 0;
  logic [63:0] mosi_bits = '0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, miso_r = 1'b0;
  // Stimulus-side controls, written only by the main initial block.
  int          sel = 0;
  logic        loopback = 1'b0;
  logic [63:0] slave_frame = '0;
  int          acc_cyc = 0;
  int          n_checks = 0, n_pass = 0;

  assign miso_in = loopback ? mosi_w : {3{miso_r}};

  spi_frame_master #(.DATA_W(P0_DW), .CLK_DIV(P0_CD), .GAP_CYCLES(P0_GAP), .CPOL(P0_CPOL), .CPHA(P0_CPHA)) u_dut0 (
    .clk(clk), .reset(reset), .i_valid(valid[0]), .i_data(data_in[0][P0_DW-1:0]), .o_ready(ready_w[0]),
    .i_abort(abort_in[0]), .o_busy(busy_w[0]), .o_done(done_w[0]), .o_aborted(aborted_w[0]),
    .o_rx_data(rx0), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_in[0]), .ss(ss_w[0]));

  spi_frame_master #(.DATA_W(P1_DW), .CLK_DIV(P1_CD), .GAP_CYCLES(P1_GAP), .CPOL(P1_CPOL), .CPHA(P1_CPHA)) u_dut1 (
    .clk(clk), .reset(reset), .i_valid(valid[1]), .i_data(data_in[1][P1_DW-1:0]), .o_ready(ready_w[1]),
    .i_abort(abort_in[1]), .o_busy(busy_w[1]), .o_done(done_w[1]), .o_aborted(aborted_w[1]),
    .o_rx_data(rx1), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_in[1]), .ss(ss_w[1]));

  spi_frame_master #(.DATA_W(P2_DW), .CLK_DIV(P2_CD), .GAP_CYCLES(P2_GAP), .CPOL(P2_CPOL), .CPHA(P2_CPHA)) u_dut2 (
    .clk(clk), .reset(reset), .i_valid(valid[2]), .i_data(data_in[2][P2_DW-1:0]), .o_ready(ready_w[2]),
    .i_abort(abort_in[2]), .o_busy(busy_w[2]), .o_done(done_w[2]), .o_aborted(aborted_w[2]),
    .o_rx_data(rx2), .sclk(sclk_w[2]), .mosi(mosi_w[2]), .miso(miso_in[2]), .ss(ss_w[2]));

  function automatic int dw_of(int k);
    case (k) 0: return P0_DW; 1: return P1_DW; default: return P2_DW; endcase
  endfunction
  function automatic int cd_of(int k);
    case (k) 0: return P0_CD; 1: return P1_CD; default: return P2_CD; endcase
  endfunction
  function automatic int gap_of(int k);
    case (k) 0: return P0_GAP; 1: return P1_GAP; default: return P2_GAP; endcase
  endfunction
  function automatic logic cpol_of(int k);
    case (k) 0: return P0_CPOL; 1: return P1_CPOL; default: return P2_CPOL; endcase
  endfunction
  function automatic logic cpha_of(int k);
    case (k) 0: return P0_CPHA; 1: return P1_CPHA; default: return P2_CPHA; endcase
  endfunction
  function automatic int nb_of(int k);
    return (dw_of(k) + 7) / 8;
  endfunction
  function automatic logic [63:0] get_rx(int k);
    case (k) 0: return 64'(rx0); 1: return 64'(rx1); default: return 64'(rx2); endcase
  endfunction
  function automatic logic slave_bit(int p);
    int fb;
    fb = 8 * nb_of(sel);
    if (p >= fb) return 1'b0;
    return slave_frame[fb-1-p];
  endfunction

  // Pin-level SPI slave and monitor for the selected instance, sampled on the falling clk edge.
  always @(negedge clk) begin
    logic s_ss, s_sclk, s_mosi, lead;
    s_ss   = ss_w[sel];
    s_sclk = sclk_w[sel];
    s_mosi = mosi_w[sel];
    if (s_ss === 1'b1 && (s_sclk !== cpol_of(sel) || s_mosi !== 1'b0)) bad_idle++;
    if (s_ss === 1'b0 && prev_ss === 1'b1) begin
      edges = 0; nbits = 0; ss_low = 0; bad_mosi = 0; mosi_bits = '0; pidx = 0;
      if (!cpha_of(sel)) begin
        miso_r = slave_bit(0);
        pidx = 1;
      end
    end
    if (s_ss === 1'b0) begin
      ss_low++;
      if (s_sclk !== prev_sclk) begin
        edges++;
        lead = (edges % 2) == 1;
        if (lead == !cpha_of(sel)) begin
          if (s_mosi !== prev_mosi) bad_mosi++;
          mosi_bits = {mosi_bits[62:0], s_mosi};
          nbits++;
        end else begin
          miso_r = slave_bit(pidx);
          pidx++;
        end
      end
    end
    if (done_w[sel] === 1'b1) done_cnt++;
    if (aborted_w[sel] === 1'b1) abort_cnt++;
    prev_ss = s_ss; prev_sclk = s_sclk; prev_mosi = s_mosi;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic send(input int k, input logic [31:0] d);
    @(posedge clk); #1;
    check("ready_before_accept", 64'(ready_w[k]), 64'd1);
    valid[k] = 1'b1;
    data_in[k] = d;
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_w[k]) begin found = 1'b1; break; end
    end
    check("done_within_budget", 64'(found), 64'd1);
    lat = cyc - acc_cyc;
  endtask

  // Called in the o_done cycle; compares the observed frame with what the rules predict.
  task automatic frame_checks(input int k, input logic [63:0] d, input logic [63:0] sf, input logic lb, input int lat);
    int fb, cd, exp_ss;
    logic [63:0] dmask;
    fb     = 8 * nb_of(k);
    cd     = cd_of(k);
    exp_ss = cd + nb_of(k) * 16 * cd + (nb_of(k) - 1) * gap_of(k) + cd;
    dmask  = (64'd1 << dw_of(k)) - 64'd1;
    check("mosi_frame", mosi_bits & ((64'd1 << fb) - 64'd1), d & dmask);
    check("sclk_pulses", 64'(nbits), 64'(fb));
    check("sclk_edges", 64'(edges), 64'(2 * fb));
    check("ss_low_cycles", 64'(ss_low), 64'(exp_ss));
    check("done_latency", 64'(lat), 64'(exp_ss + 1));
    check("rx_data", get_rx(k), (lb ? d : sf) & dmask);
    check("mosi_stable_at_sample", 64'(bad_mosi), 64'd0);
    check("ss_high_at_done", 64'(ss_w[k]), 64'd1);
    check("ready_at_done", 64'(ready_w[k]), 64'd1);
  endtask

  task automatic run(input int k, input logic [31:0] d, input logic [63:0] sf, input logic lb);
    int lat;
    sel = k;
    loopback = lb;
    slave_frame = sf;
    send(k, d);
    wait_done(k, lat);
    frame_checks(k, 64'(d), sf, lb, lat);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done_w[k]), 64'd0);
  endtask

  initial begin
    int lat, ready_seen, dc, ac;
    logic [31:0] a, b;
    logic [63:0] sf, rx_before;
    bit found;
    for (int i = 0; i < 3; i++) data_in[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      check("reset_ss", 64'(ss_w[k]), 64'd1);
      check("reset_sclk", 64'(sclk_w[k]), 64'(cpol_of(k)));
      check("reset_mosi", 64'(mosi_w[k]), 64'd0);
      check("reset_flags", 64'({done_w[k], aborted_w[k], busy_w[k], ready_w[k]}), 64'b0001);
      check("reset_rx", get_rx(k), 64'd0);
    end

    run(0, 32'h2A5C, 64'h15A3, 1'b0);
    run(1, 32'hC3A5, 64'h0, 1'b1);
    run(2, 32'h81, 64'h5A, 1'b0);
    for (int i = 0; i < 9; i++) run(i % 3, $urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Back-to-back: valid held high with wandering data; next word taken in the o_done cycle.
    sel = 0; loopback = 1'b0; sf = 64'($urandom); slave_frame = sf;
    @(posedge clk); #1;
    a = $urandom;
    check("b2b_ready_before", 64'(ready_w[0]), 64'd1);
    valid[0] = 1'b1; data_in[0] = a; acc_cyc = cyc;
    ready_seen = 0; found = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin found = 1'b1; break; end
      if (ready_w[0]) ready_seen++;
      data_in[0] = $urandom;
    end
    check("b2b_done_within_budget", 64'(found), 64'd1);
    check("b2b_ready_low_while_busy", 64'(ready_seen), 64'd0);
    lat = cyc - acc_cyc;
    frame_checks(0, 64'(a), sf, 1'b0, lat);
    b = data_in[0];
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    check("b2b_ss_high_one_cycle", 64'(ss_w[0]), 64'd0);
    check("b2b_second_busy", 64'(busy_w[0]), 64'd1);
    wait_done(0, lat);
    frame_checks(0, 64'(b), sf, 1'b0, lat);

    // Abort around the fifth sclk edge of byte 0.
    @(posedge clk); #1;
    rx_before = get_rx(0); dc = done_cnt; ac = abort_cnt;
    send(0, $urandom);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (edges >= 5) break;
    end
    check("abort_reached_edge5", 64'(edges), 64'd5);
    abort_in[0] = 1'b1;
    @(posedge clk); #1;
    abort_in[0] = 1'b0;
    check("abort_ss", 64'(ss_w[0]), 64'd1);
    check("abort_sclk", 64'(sclk_w[0]), 64'(P0_CPOL));
    check("abort_mosi", 64'(mosi_w[0]), 64'd0);
    check("abort_flags", 64'({aborted_w[0], done_w[0], busy_w[0], ready_w[0]}), 64'b1001);
    @(posedge clk); #1;
    check("abort_one_cycle", 64'(aborted_w[0]), 64'd0);
    repeat (200) @(posedge clk);
    #1;
    check("abort_pulse_count", 64'(abort_cnt - ac), 64'd1);
    check("abort_no_done", 64'(done_cnt - dc), 64'd0);
    check("abort_rx_kept", get_rx(0), rx_before);

    // Synchronous reset in the middle of byte 1.
    dc = done_cnt; ac = abort_cnt;
    send(0, $urandom);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (edges >= 20) break;
    end
    check("reset_reached_byte1", 64'(edges), 64'd20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_ss", 64'(ss_w[0]), 64'd1);
    check("midreset_sclk", 64'(sclk_w[0]), 64'(P0_CPOL));
    check("midreset_mosi", 64'(mosi_w[0]), 64'd0);
    check("midreset_rx", get_rx(0), 64'd0);
    check("midreset_flags", 64'({done_w[0], aborted_w[0], busy_w[0], ready_w[0]}), 64'b0001);
    repeat (200) @(posedge clk);
    #1;
    check("midreset_no_pulses", 64'((done_cnt - dc) + (abort_cnt - ac)), 64'd0);
    check("idle_pins_quiet", 64'(bad_idle), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
